fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drain stage on the read side of the cascaded 36-bit FIFO. It converts the standard-mode read interface (data valid one cycle after `rd_en`) into a valid/ready stream for downstream logic. Reads are prefetched into a small register buffer and gated by credits, so the FIFO is never over-read and a stalled consumer never loses a word. It also keeps a count of delivered words and lives entirely in the `rd_clk` domain.

## Interface
- `DATA_W`, 36: word width; must equal the FIFO width.
- `BUF_DEPTH`, 4: output buffer entries; a power of two, ≥ 3 (3 needed for full throughput).
- `CNT_W`, 32: width of the delivered-word counter.

Ports:
- `rd_clk`  in  1  the only clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_dout`  in  DATA_W  FIFO read data, valid in the cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational from registered state and `fifo_empty`).
- `drain_en`  in  1  when 0, no new reads are issued; buffered and in-flight words still deliver.
- `out_data`  out  DATA_W  head of the buffer.
- `out_valid`  out  1  buffer non-empty.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid & out_ready`.
- `word_cnt`  out  CNT_W  count of words transferred on the output port.

## Operation
- State registers:
  - `pending`: 1 bit, a read issued last cycle whose data arrives this cycle.
  - `count`: 0..BUF_DEPTH.
  - Write and read pointers: log2(BUF_DEPTH) bits, wrapping naturally.
  - Register array: BUF_DEPTH × DATA_W.
- Read issue: `fifo_rd_en = drain_en & ~fifo_empty & (count + pending < BUF_DEPTH)`.
  - Credit arithmetic uses log2(BUF_DEPTH)+1 bits; no overflow is possible.
  - A same-cycle pop does not free a credit. There is no combinational path from `out_ready` to `fifo_rd_en`.
- Capture: `pending <= fifo_rd_en`. When `pending` = 1, write `fifo_dout` at the write pointer and increment the write pointer.
- Pop: on `out_valid & out_ready`, increment the read pointer and `word_cnt`.
  - `word_cnt` wraps modulo 2^CNT_W and never saturates.
- Count update: `count <= count + pending - pop`. A simultaneous capture and pop leaves `count` unchanged.
- Outputs: `out_valid = (count != 0)`, `out_data = buf[rd_ptr]`.
  - `out_data` must hold stable while `out_valid & ~out_ready`.
- Invariant: `count + pending ≤ BUF_DEPTH` always, so a capture never finds the buffer full.
- Empty boundary:
  - `fifo_rd_en` is never high while `fifo_empty` = 1, so underflow is impossible.
  - `fifo_empty` rising in the same cycle as a read does not cancel that read's capture.
- `drain_en` falling: a read already issued is still captured next cycle.
- Reset, asynchronous assert:
  - Registers: `pending`=0, `count`=0, pointers=0, `word_cnt`=0.
  - Outputs: `out_valid`=0, `fifo_rd_en`=0.
  - `out_data`: buffer contents are don't-care but must not be X-propagating into control; reset them to 0.
  - In-flight and buffered words are discarded. The system resets the FIFO in the same window.
- Reset deassertion is assumed synchronised to `rd_clk` externally.

## Timing
- Read latency:
  - `fifo_rd_en` high in cycle k.
  - `fifo_dout` sampled at the end of cycle k+1.
  - `out_valid` high in cycle k+2.
- First word after `fifo_empty` falls in cycle k (buffer empty, `drain_en`=1): `out_valid` rises in cycle k+2.
- Throughput: with `out_ready` held high and the FIFO non-empty, one word per cycle is sustained after the first two cycles.
- Back-pressure: with `out_ready` = 0, at most BUF_DEPTH reads are issued, then `fifo_rd_en` stays low.
  - On `out_ready` rising, reads resume the cycle after the first pop.
- `word_cnt` updates on the edge that ends the transfer cycle.

## Test plan
- Reset: hold `rst_n`=0 with the FIFO non-empty → `fifo_rd_en`=0, `out_valid`=0, `word_cnt`=0. Assert `rst_n` low mid-stream → all of these clear immediately, without waiting for a clock.
- Latency: FIFO holds 0x000000001, `fifo_empty` falls in cycle 5, `out_ready`=1 → `fifo_rd_en` high in cycle 5, `out_valid` with `out_data`=0x000000001 in cycle 7, `word_cnt`=1 afterwards.
- Streaming: 100 words with incrementing values 0..99, `out_ready`=1 → output in order with no gap after the first word, `word_cnt`=100, and no `fifo_rd_en` while `fifo_empty`=1.
- Back-pressure: 10 words queued, `out_ready`=0 for 20 cycles → exactly 4 reads issued, `out_data` held at word 0. Release `out_ready` → words 0..9 delivered in order with no loss or duplication.
- `drain_en`: drop `drain_en` in the cycle of a read → that word is still delivered and no further reads occur. Raise `drain_en` → reads resume.
- Random: random `fifo_empty`, `out_ready` and `drain_en` over 10k cycles against a scoreboard → data matches, the `count + pending ≤ 4` assertion holds, and `word_cnt` equals the scoreboard count. Force `word_cnt` near 2^32−1 → it wraps to 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for the cascaded FIFO: turns the one-cycle-latency read
// port into a valid/ready stream through a credit-gated prefetch buffer.
module fifo_stream_reader #(
  parameter int DATA_W    = 36,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              drain_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam logic [CRD_W-1:0] DEPTH_CRD = CRD_W'(BUF_DEPTH);

  logic              pending;
  logic [CRD_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
  logic [CRD_W-1:0]  credits_used;
  logic              pop;

  // The in-flight read holds a credit; a same-cycle pop frees nothing, which
  // keeps out_ready off the combinational path to fifo_rd_en.
  assign credits_used = count + CRD_W'(pending);
  assign fifo_rd_en   = rst_n & drain_en & ~fifo_empty & (credits_used < DEPTH_CRD);
  assign out_valid    = (count != '0);
  assign pop          = out_valid & out_ready;
  assign out_data     = buf_mem[rd_ptr];

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
    end else begin
      pending <= fifo_rd_en;
      count   <= count + CRD_W'(pending) - CRD_W'(pop);
      if (pending) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  // Entries are cleared so out_data never carries X after reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (pending) begin
      buf_mem[wr_ptr] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-level model of the prefetch buffer is
// compared every cycle, plus hand-computed checks for reset, latency and flow control.
module tb_fifo_stream_reader;

  localparam int DATA_W = 36;
  localparam int DEPTH  = 4;

  logic              rd_clk     = 1'b0;
  logic              rst_n      = 1'b1;
  logic [DATA_W-1:0] fifo_dout  = '0;
  logic              fifo_empty = 1'b1;
  logic              drain_en   = 1'b0;
  logic              out_ready  = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [31:0]       word_cnt;
  logic              fifo_rd_en_w;
  logic [DATA_W-1:0] out_data_w;
  logic              out_valid_w;
  logic [3:0]        word_cnt_w;

  fifo_stream_reader #(.DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .CNT_W(32)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .drain_en(drain_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
  );

  // Narrow counter copy so wrap-around is reached in a short run.
  fifo_stream_reader #(.DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .CNT_W(4)) dut_wrap (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en_w), .drain_en(drain_en), .out_data(out_data_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .word_cnt(word_cnt_w)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] got[$];
  int                env_idx  = 0;
  logic              force_ne = 1'b0;
  logic              check_en = 1'b0;
  int                n_vec    = 0;
  int                n_err    = 0;

  logic [DATA_W-1:0] mq[$];
  logic              m_pend      = 1'b0;
  logic [DATA_W-1:0] m_pend_word = '0;
  logic [31:0]       m_cnt       = '0;
  int                mdl_idx     = 0;

  // Standard-mode FIFO: data appears the cycle after the strobe; reset flushes it.
  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      env_idx <= src_q.size();
    end else if (fifo_rd_en) begin
      fifo_dout <= (env_idx < src_q.size()) ? src_q[env_idx] : '0;
      env_idx   <= env_idx + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic modelRdEn();
    return rst_n && drain_en && !fifo_empty && ((mq.size() + (m_pend ? 1 : 0)) < DEPTH);
  endfunction

  task automatic modelStep();
    logic rd;
    if (!rst_n) begin
      mq.delete();
      m_pend  = 1'b0;
      m_cnt   = '0;
      mdl_idx = src_q.size();
    end else begin
      rd = modelRdEn();
      if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 1;
      end
      if (m_pend) mq.push_back(m_pend_word);
      m_pend = rd;
      if (rd) begin
        m_pend_word = (mdl_idx < src_q.size()) ? src_q[mdl_idx] : '0;
        mdl_idx++;
      end
    end
  endtask

  initial forever begin
    @(posedge rd_clk or negedge rst_n);
    modelStep();
  end

  initial begin : compare_proc
    logic exp_valid;
    forever begin
      @(negedge rd_clk);
      if (check_en) begin
        exp_valid = (mq.size() != 0);
        checkOutput("fifo_rd_en", 64'(fifo_rd_en), 64'(modelRdEn()));
        checkOutput("rd_while_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
        checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) checkOutput("out_data", 64'(out_data), 64'(mq[0]));
        checkOutput("word_cnt", 64'(word_cnt), 64'(m_cnt));
        checkOutput("wrap_rd_en", 64'(fifo_rd_en_w), 64'(modelRdEn()));
        checkOutput("wrap_valid", 64'(out_valid_w), 64'(exp_valid));
        if (exp_valid) checkOutput("wrap_data", 64'(out_data_w), 64'(mq[0]));
        checkOutput("wrap_word_cnt", 64'(word_cnt_w), 64'(m_cnt[3:0]));
        if (out_valid && out_ready) got.push_back(out_data);
      end
    end
  end

  task automatic applyStimulus(input logic d, input logic r, input logic h);
    @(posedge rd_clk);
    #1;
    drain_en   = d;
    out_ready  = r;
    fifo_empty = force_ne ? 1'b0 : (h || env_idx >= src_q.size());
    @(negedge rd_clk);
  endtask

  task automatic pushWords(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) src_q.push_back(base + DATA_W'(i));
  endtask

  task automatic midReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rd_en", 64'(fifo_rd_en), 64'(0));
    checkOutput("async_rst_valid", 64'(out_valid), 64'(0));
    checkOutput("async_rst_word_cnt", 64'(word_cnt), 64'(0));
    checkOutput("async_rst_wrap_cnt", 64'(word_cnt_w), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge rd_clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    int first_v, last_v, n_valid, n_rd, g0;
    logic [63:0] r64;

    #1 rst_n = 1'b0;
    force_ne = 1'b1;
    #1 check_en = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset_rd_en", 64'(fifo_rd_en), 64'(0));
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_word_cnt", 64'(word_cnt), 64'(0));
    force_ne   = 1'b0;
    fifo_empty = 1'b1;
    @(posedge rd_clk);
    #1 rst_n = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);

    // Single word: strobe in k, valid in k+2, counted after.
    pushWords(1, 36'h000000001);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lat_rd_en_k", 64'(fifo_rd_en), 64'(1));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lat_valid_k1", 64'(out_valid), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lat_valid_k2", 64'(out_valid), 64'(1));
    checkOutput("lat_data_k2", 64'(out_data), 64'h1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("lat_word_cnt", 64'(word_cnt), 64'(1));

    // 100-word stream must come out gap-free after the first word.
    g0 = got.size();
    pushWords(100, '0);
    first_v = -1; last_v = -1; n_valid = 0;
    for (int c = 0; c < 110; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        n_valid++;
      end
    end
    checkOutput("stream_valid_cycles", 64'(n_valid), 64'(100));
    checkOutput("stream_span", 64'(last_v - first_v), 64'(99));
    checkOutput("stream_got_n", 64'(got.size() - g0), 64'(100));
    for (int i = 0; i < 100 && g0 + i < got.size(); i++)
      checkOutput("stream_order", 64'(got[g0 + i]), 64'(i));
    checkOutput("stream_word_cnt", 64'(word_cnt), 64'(101));
    checkOutput("stream_wrap_cnt", 64'(word_cnt_w), 64'(5));

    // Stalled consumer: only DEPTH reads, head word held.
    pushWords(10, 36'h100);
    n_rd = 0;
    repeat (20) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (fifo_rd_en) n_rd++;
    end
    checkOutput("bp_reads", 64'(n_rd), 64'(4));
    checkOutput("bp_hold_valid", 64'(out_valid), 64'(1));
    checkOutput("bp_hold_data", 64'(out_data), 64'h100);
    g0 = got.size();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp_no_rd_at_release", 64'(fifo_rd_en), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp_rd_resume", 64'(fifo_rd_en), 64'(1));
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp_got_n", 64'(got.size() - g0), 64'(10));
    for (int i = 0; i < 10 && g0 + i < got.size(); i++)
      checkOutput("bp_order", 64'(got[g0 + i]), 64'h100 + 64'(i));
    checkOutput("bp_word_cnt", 64'(word_cnt), 64'(111));
    checkOutput("bp_wrap_cnt", 64'(word_cnt_w), 64'(15));

    // drain_en drop right after a read: that word still delivers, nothing else.
    pushWords(5, 36'h200);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dr_idle", 64'(fifo_rd_en), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("dr_read", 64'(fifo_rd_en), 64'(1));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dr_stop", 64'(fifo_rd_en), 64'(0));
    g0 = got.size();
    n_rd = 0;
    repeat (8) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (fifo_rd_en) n_rd++;
    end
    checkOutput("dr_no_reads", 64'(n_rd), 64'(0));
    checkOutput("dr_got_n", 64'(got.size() - g0), 64'(1));
    if (got.size() > g0) checkOutput("dr_word", 64'(got[g0]), 64'h200);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("dr_resume", 64'(fifo_rd_en), 64'(1));
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("dr_word_cnt", 64'(word_cnt), 64'(116));
    checkOutput("dr_wrap_cnt", 64'(word_cnt_w), 64'(4));

    // Random traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 10000; c++) begin
      if (int'(src_q.size()) - env_idx < 6) begin
        repeat (4) begin
          r64 = {$urandom, $urandom};
          src_q.push_back(r64[DATA_W-1:0]);
        end
      end
      if (c == 5000) midReset();
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0);
    end
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
